// File: rtl/intr_receiver_if.sv
// Interrupt receiver bus: control inputs, status and timing outputs.
// master drives controls and line; slave is the receiver block.
interface intr_receiver_if;
    logic        enable;
    logic        intr_in;
    logic        intr_polarity;
    logic        intr_type;
    logic        ack;
    logic        err_clear;
    logic [15:0] release_timeout;

    logic        intr_release;
    logic        pending;
    logic        overrun;
    logic        timeout_err;
    logic [31:0] irq_count;
    logic [31:0] stamp_lo;
    logic [31:0] stamp_hi;
    logic [31:0] period;
    logic [1:0]  state;

    modport master (
        output enable, intr_in, intr_polarity, intr_type,
        output ack, err_clear, release_timeout,
        input  intr_release, pending, overrun, timeout_err,
        input  irq_count, stamp_lo, stamp_hi, period, state
    );

    modport slave (
        input  enable, intr_in, intr_polarity, intr_type,
        input  ack, err_clear, release_timeout,
        output intr_release, pending, overrun, timeout_err,
        output irq_count, stamp_lo, stamp_hi, period, state
    );
endinterface

// File: rtl/intr_receiver.sv
// Interrupt receiver: synchronises an async interrupt line, time-stamps
// accepted edges, tracks period, and runs the ack/release handshake.
// Ports: clk, reset_n (async, active-low), bus (intr_receiver_if.slave).
module intr_receiver #(
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    intr_receiver_if.slave  bus
);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] PENDING    = 2'd1;
    localparam logic [1:0] RELEASE    = 2'd2;
    localparam logic [1:0] WAIT_INACT = 2'd3;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   act;
    logic                   act_d;
    logic                   rise;

    logic [1:0]  state_q;
    logic [1:0]  state_nx;
    logic [63:0] local_time;
    logic [31:0] period_cnt;
    logic [31:0] period_next;
    logic        first_rise;
    logic [15:0] wait_cnt;

    logic        accept;
    logic        overrun_set;
    logic        timeout_set;
    logic        wait_clr;
    logic        wait_inc;

    logic [31:0] irq_count_q;
    logic [31:0] stamp_lo_q;
    logic [31:0] stamp_hi_q;
    logic [31:0] period_q;
    logic        overrun_q;
    logic        timeout_q;

    // Line polarity is applied after the synchroniser so a polarity
    // change never creates a metastable path.
    assign act  = bus.intr_polarity ? sync_q[SYNC_STAGES-1]
                                    : ~sync_q[SYNC_STAGES-1];
    assign rise = bus.enable & act & ~act_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            act_d  <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.intr_in};
            act_d  <= act;
        end
    end

    always_comb begin
        state_nx    = state_q;
        accept      = 1'b0;
        overrun_set = 1'b0;
        timeout_set = 1'b0;
        wait_clr    = 1'b0;
        wait_inc    = 1'b0;
        if (!bus.enable) begin
            state_nx = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_nx = PENDING;
                        accept   = 1'b1;
                    end
                end
                PENDING: begin
                    overrun_set = rise;
                    if (bus.ack) begin
                        state_nx = bus.intr_type ? RELEASE : IDLE;
                    end
                end
                RELEASE: begin
                    wait_clr = 1'b1;
                    state_nx = WAIT_INACT;
                end
                WAIT_INACT: begin
                    if (!act) begin
                        state_nx = IDLE;
                    end else if (bus.release_timeout != 16'd0 &&
                                 wait_cnt == bus.release_timeout) begin
                        timeout_set = 1'b1;
                        state_nx    = IDLE;
                    end else begin
                        wait_inc = 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // First edge after enable has no valid predecessor, so its period is 0.
    always_comb begin
        if (first_rise) begin
            period_next = 32'd0;
        end else if (period_cnt == 32'hFFFF_FFFF) begin
            period_next = 32'hFFFF_FFFF;
        end else begin
            period_next = period_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            local_time <= 64'd0;
            period_cnt <= 32'd0;
            first_rise <= 1'b1;
            wait_cnt   <= 16'd0;
        end else begin
            state_q <= state_nx;
            if (!bus.enable) begin
                local_time <= 64'd0;
                period_cnt <= 32'd0;
                first_rise <= 1'b1;
            end else begin
                local_time <= local_time + 64'd1;
                if (accept) begin
                    period_cnt <= 32'd0;
                    first_rise <= 1'b0;
                end else if (period_cnt != 32'hFFFF_FFFF) begin
                    period_cnt <= period_cnt + 32'd1;
                end
            end
            if (wait_clr) begin
                wait_cnt <= 16'd0;
            end else if (wait_inc) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_count_q <= 32'd0;
            stamp_lo_q  <= 32'd0;
            stamp_hi_q  <= 32'd0;
            period_q    <= 32'd0;
        end else begin
            if (accept || overrun_set) begin
                irq_count_q <= irq_count_q + 32'd1;
            end
            if (accept) begin
                stamp_lo_q <= local_time[31:0];
                stamp_hi_q <= local_time[63:32];
                period_q   <= period_next;
            end
        end
    end

    // Sticky flags: a new error in the same cycle as err_clear stays set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (overrun_set) begin
                overrun_q <= 1'b1;
            end else if (bus.err_clear) begin
                overrun_q <= 1'b0;
            end
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end else if (bus.err_clear) begin
                timeout_q <= 1'b0;
            end
        end
    end

    assign bus.state        = state_q;
    assign bus.pending      = (state_q == PENDING);
    assign bus.intr_release = (state_q == RELEASE) & bus.enable;
    assign bus.overrun      = overrun_q;
    assign bus.timeout_err  = timeout_q;
    assign bus.irq_count    = irq_count_q;
    assign bus.stamp_lo     = stamp_lo_q;
    assign bus.stamp_hi     = stamp_hi_q;
    assign bus.period       = period_q;

endmodule

// File: doc/intr_receiver.md
INTR_RECEIVER -- requirements
Module: intr_receiver

Interface
REQ-001 Parameter SYNC_STAGES, default 2, SHALL set the number of synchroniser flops on intr_in (legal 2..4).
REQ-002 clk  input  1  system clock, all logic on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 enable  input  1  block enable; 0 forces idle.
REQ-005 intr_in  input  1  interrupt line from time generator, asynchronous to clk.
REQ-006 intr_polarity  input  1  1 = active-high line, 0 = active-low.
REQ-007 intr_type  input  1  0 = self-timed pulse, 1 = level held until released.
REQ-008 ack  input  1  single-cycle software acknowledge.
REQ-009 err_clear  input  1  single-cycle clear of sticky error flags.
REQ-010 release_timeout  input  16  max cycles to wait for line deassert after release; 0 = no limit.
REQ-011 intr_release  output  1  one-cycle release pulse to the interrupt source.
REQ-012 pending  output  1  unacknowledged interrupt held.
REQ-013 overrun  output  1  sticky: interrupt arrived while pending.
REQ-014 timeout_err  output  1  sticky: line stayed active past release_timeout.
REQ-015 irq_count  output  32  accepted-interrupt counter.
REQ-016 stamp_lo / stamp_hi  output  32 each  local time at last accepted interrupt.
REQ-017 period  output  32  cycles between last two accepted interrupts.
REQ-018 state  output  2  FSM state, for debug.

Function
REQ-019 intr_in SHALL pass through SYNC_STAGES flops; act = polarity ? sync : ~sync.
REQ-020 Edge detect SHALL be rise = enable & act & ~act_d; act_d SHALL reset to 1, so a line already active at reset or enable gives no event.
REQ-021 Latency: with SYNC_STAGES=2, pending SHALL rise on the 3rd clk edge after intr_in becomes active.
REQ-022 Local time SHALL be a 64-bit counter, +1 per cycle while enable=1, cleared to 0 while enable=0, wrapping modulo 2^64.
REQ-023 FSM states: IDLE=0, PENDING=1, RELEASE=2, WAIT_INACT=3.
REQ-024 IDLE: on rise go to PENDING; set pending; capture local time into stamp_hi:stamp_lo; increment irq_count.
REQ-025 PENDING + ack: with intr_type=0 go to IDLE; with intr_type=1 go to RELEASE. pending SHALL clear in the same edge.
REQ-026 PENDING + rise (with or without ack): overrun SHALL set and irq_count SHALL increment; stamp and period SHALL NOT update.
REQ-027 RELEASE: intr_release=1 for exactly this one cycle; load the timeout counter with 0; go to WAIT_INACT.
REQ-028 WAIT_INACT: act=0 goes to IDLE. Otherwise, when release_timeout!=0 and the counter equals release_timeout, set timeout_err and go to IDLE. Otherwise the counter increments.
REQ-029 Period counter (32-bit) SHALL increment each enabled cycle, saturate at 0xFFFFFFFF, and restart at 0 on each accepted rise (IDLE only).
REQ-030 On an accepted rise, period SHALL load count+1 (saturating). The first rise after enable SHALL load 0.
REQ-031 ack outside PENDING SHALL be ignored.
REQ-032 err_clear SHALL clear overrun and timeout_err; a set in the same cycle SHALL win.
REQ-033 irq_count SHALL wrap 0xFFFFFFFF -> 0.
REQ-034 enable=0 SHALL force state=IDLE, pending=0, intr_release=0 and clear the local-time and period counters. irq_count, stamps, period and sticky flags SHALL retain their values.

Reset
REQ-035 On reset_n=0: all outputs 0, state=IDLE, sync flops 0, act_d=1, all counters 0, first-rise flag set; takes effect immediately and overrides any mid-operation state.

Verification
REQ-036 Reset, enable=1, polarity=1, type=0, intr_in pulse at cycle 100 -> pending at edge 102, irq_count=1, stamp_lo=101, period=0; ack -> pending=0, state=IDLE.
REQ-037 Second pulse 1000 cycles later (after ack) -> period=1000, irq_count=2, stamp_lo=1101.
REQ-038 type=1, line held high, ack -> intr_release one cycle; line drops 5 cycles later -> IDLE, timeout_err=0.
REQ-039 type=1, release_timeout=20, line never drops -> timeout_err=1 after 20 WAIT_INACT cycles, state IDLE; err_clear -> 0.
REQ-040 Two pulses with no ack -> overrun=1, irq_count=2, stamp unchanged; polarity=0 with line low at reset -> no event until line goes high then low.
REQ-041 reset_n asserted in WAIT_INACT -> all outputs 0 immediately; enable dropped in PENDING -> pending=0, irq_count retained.
